// File: rtl/ex_shad_arb.sv
// ex_shad_arb: round-robin sequencer sharing one SHAD/SHLD shifter between req0 (EX pipe) and req1 (microcode); ports: reqN valid/ready/Rs/Rt/Op in, respN valid/ready with shared respData/respErr out, shRs/shRt/shOp to and shRn from the shifter
module ex_shad_arb (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0Valid,
  input  logic [31:0] req0Rs,
  input  logic [7:0]  req0Rt,
  input  logic [2:0]  req0Op,
  output logic        req0Ready,
  input  logic        req1Valid,
  input  logic [31:0] req1Rs,
  input  logic [7:0]  req1Rt,
  input  logic [2:0]  req1Op,
  output logic        req1Ready,
  output logic        resp0Valid,
  input  logic        resp0Ready,
  output logic        resp1Valid,
  input  logic        resp1Ready,
  output logic [31:0] respData,
  output logic        respErr,
  output logic [31:0] shRs,
  output logic [7:0]  shRt,
  output logic [2:0]  shOp,
  input  logic [31:0] shRn
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;
  stateT state;
  logic [31:0] opRs;
  logic [7:0] opRt;
  logic [2:0] opOp;
  logic owner, lastGrant, grant0, grant1, illegal, drive;
  always_comb begin
    grant0 = req0Valid & (~req1Valid | lastGrant);
    grant1 = req1Valid & (~req0Valid | ~lastGrant);
    req0Ready = (state == IDLE) & grant0;
    req1Ready = (state == IDLE) & grant1;
    illegal = opOp > 3'd4;
    drive = (state == EXEC) & ~illegal;
    shRs = drive ? opRs : '0;
    shRt = drive ? opRt : '0;
    shOp = drive ? opOp : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      opRs <= '0;
      opRt <= '0;
      opOp <= '0;
      owner <= 1'b0;
      lastGrant <= 1'b1;
      respData <= '0;
      respErr <= 1'b0;
      resp0Valid <= 1'b0;
      resp1Valid <= 1'b0;
    end else if (state == IDLE) begin
      if (grant0 | grant1) begin
        opRs <= grant1 ? req1Rs : req0Rs;
        opRt <= grant1 ? req1Rt : req0Rt;
        opOp <= grant1 ? req1Op : req0Op;
        owner <= grant1;
        lastGrant <= grant1;
        state <= EXEC;
      end
    end else if (state == EXEC) begin
      respData <= illegal ? '0 : shRn;
      respErr <= illegal;
      resp0Valid <= ~owner;
      resp1Valid <= owner;
      state <= RESP;
    end else if (owner ? resp1Ready : resp0Ready) begin
      resp0Valid <= 1'b0;
      resp1Valid <= 1'b0;
      state <= IDLE;
    end
endmodule

// File: tb/tb_ex_shad_arb.sv
// tb_ex_shad_arb: directed checks of ex_shad_arb with a behavioural shifter model on shRn
module tb_ex_shad_arb;
  logic clock = 1'b0, reset = 1'b0;
  logic req0Valid = 1'b0, req1Valid = 1'b0, req0Ready, req1Ready;
  logic [31:0] req0Rs = '0, req1Rs = '0;
  logic [7:0] req0Rt = '0, req1Rt = '0;
  logic [2:0] req0Op = '0, req1Op = '0;
  logic resp0Valid, resp1Valid, resp0Ready = 1'b0, resp1Ready = 1'b0;
  logic [31:0] respData, shRs, shRn;
  logic respErr;
  logic [7:0] shRt;
  logic [2:0] shOp;
  int vecs = 0, errs = 0;

  always #5 clock = ~clock;

  ex_shad_arb dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req0Rs(req0Rs), .req0Rt(req0Rt), .req0Op(req0Op), .req0Ready(req0Ready),
    .req1Valid(req1Valid), .req1Rs(req1Rs), .req1Rt(req1Rt), .req1Op(req1Op), .req1Ready(req1Ready),
    .resp0Valid(resp0Valid), .resp0Ready(resp0Ready), .resp1Valid(resp1Valid), .resp1Ready(resp1Ready),
    .respData(respData), .respErr(respErr),
    .shRs(shRs), .shRt(shRt), .shOp(shOp), .shRn(shRn)
  );

  // shifter: signed count, positive = left, negative = right; R ops negate the count
  function automatic logic [31:0] shifter(input logic [31:0] v, input logic [7:0] c, input logic [2:0] op);
    int cnt, n;
    cnt = (op == 3'd3 || op == 3'd4) ? -int'($signed(c)) : int'($signed(c));
    n = cnt < 0 ? -cnt : cnt;
    if (op == 3'd1 || op == 3'd3) return cnt >= 0 ? v << n : v >> n;
    if (op == 3'd2 || op == 3'd4) return cnt >= 0 ? v << n : 32'($signed(v) >>> n);
    return v;
  endfunction

  always_comb shRn = shifter(shRs, shRt, shOp);

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // drives one request alone and consumes its response; reports what the response ports held
  task automatic runOp(input bit who, input logic [31:0] rs, input logic [7:0] rt, input logic [2:0] op,
                       output logic v0, output logic v1, output logic [31:0] d, output logic e, output bit timeout);
    @(negedge clock);
    if (who) begin req1Rs = rs; req1Rt = rt; req1Op = op; req1Valid = 1'b1; end
    else begin req0Rs = rs; req0Rt = rt; req0Op = op; req0Valid = 1'b1; end
    timeout = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (who ? req1Ready : req0Ready) begin timeout = 1'b0; break; end
      @(negedge clock);
    end
    @(negedge clock);
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    @(negedge clock);
    v0 = resp0Valid; v1 = resp1Valid; d = respData; e = respErr;
    if (who) resp1Ready = 1'b1; else resp0Ready = 1'b1;
    @(negedge clock);
    resp0Ready = 1'b0;
    resp1Ready = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    #1;
    vecs++; if (req0Ready !== 1'b0 || req1Ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b%b want 00", req0Ready, req1Ready); end
    vecs++; if (resp0Valid !== 1'b0 || resp1Valid !== 1'b0) begin errs++; $display("FAIL reset_respValid got %b%b want 00", resp0Valid, resp1Valid); end
    vecs++; if (respData !== 32'h0 || respErr !== 1'b0) begin errs++; $display("FAIL reset_resp got %h/%b want 0/0", respData, respErr); end
    vecs++; if (shRs !== 32'h0 || shRt !== 8'h0 || shOp !== 3'h0) begin errs++; $display("FAIL reset_sh got %h/%h/%h want 0/0/0", shRs, shRt, shOp); end
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    vecs++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin errs++; $display("FAIL reset_tie got %b%b want 10", req0Ready, req1Ready); end
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clock);
    req0Rs = 32'h1; req0Rt = 8'h04; req0Op = 3'd1; req0Valid = 1'b1;
    #1;
    vecs++; if (req0Ready !== 1'b1) begin errs++; $display("FAIL single_ready got %b want 1", req0Ready); end
    @(negedge clock);
    req0Valid = 1'b0;
    #1;
    vecs++; if (req0Ready !== 1'b0 || resp0Valid !== 1'b0) begin errs++; $display("FAIL single_exec got ready=%b valid=%b want 0/0", req0Ready, resp0Valid); end
    vecs++; if (shRs !== 32'h1 || shRt !== 8'h04 || shOp !== 3'd1) begin errs++; $display("FAIL single_sh got %h/%h/%h want 1/04/1", shRs, shRt, shOp); end
    @(negedge clock);
    vecs++; if (resp0Valid !== 1'b1 || resp1Valid !== 1'b0) begin errs++; $display("FAIL single_valid got %b%b want 10", resp0Valid, resp1Valid); end
    vecs++; if (respData !== 32'h10 || respErr !== 1'b0) begin errs++; $display("FAIL single_data got %h/%b want 00000010/0", respData, respErr); end
    vecs++; if (shOp !== 3'd0) begin errs++; $display("FAIL single_idleop got %h want 0", shOp); end
    resp0Ready = 1'b1;
    @(negedge clock);
    resp0Ready = 1'b0;
    vecs++; if (resp0Valid !== 1'b0 || shOp !== 3'd0) begin errs++; $display("FAIL single_done got valid=%b shOp=%h want 0/0", resp0Valid, shOp); end
  endtask

  task automatic test_arith();
    logic v0, v1, e;
    logic [31:0] d;
    bit to;
    runOp(1'b1, 32'h80000000, 8'hFC, 3'd2, v0, v1, d, e, to);
    vecs++; if (to || v0 !== 1'b0 || v1 !== 1'b1 || d !== 32'hF8000000 || e !== 1'b0)
      begin errs++; $display("FAIL shad_neg got to=%0b v=%b%b d=%h e=%b want 0/01/f8000000/0", to, v0, v1, d, e); end
    runOp(1'b1, 32'h80000000, 8'hFC, 3'd1, v0, v1, d, e, to);
    vecs++; if (to || v1 !== 1'b1 || d !== 32'h08000000 || e !== 1'b0)
      begin errs++; $display("FAIL shld_neg got to=%0b v1=%b d=%h e=%b want 0/1/08000000/0", to, v1, d, e); end
    runOp(1'b0, 32'h80000000, 8'h04, 3'd4, v0, v1, d, e, to);
    vecs++; if (to || v0 !== 1'b1 || v1 !== 1'b0 || d !== 32'hF8000000)
      begin errs++; $display("FAIL shadr got to=%0b v=%b%b d=%h want 0/10/f8000000", to, v0, v1, d); end
    runOp(1'b0, 32'h000000F0, 8'h04, 3'd3, v0, v1, d, e, to);
    vecs++; if (to || v0 !== 1'b1 || d !== 32'h0000000F)
      begin errs++; $display("FAIL shldr got to=%0b v0=%b d=%h want 0/1/0000000f", to, v0, d); end
    runOp(1'b1, 32'h12345678, 8'h07, 3'd0, v0, v1, d, e, to);
    vecs++; if (to || v1 !== 1'b1 || d !== 32'h12345678 || e !== 1'b0)
      begin errs++; $display("FAIL pass got to=%0b v1=%b d=%h e=%b want 0/1/12345678/0", to, v1, d, e); end
  endtask

  task automatic test_contention();
    applyReset();
    @(negedge clock);
    req0Rs = 32'h1; req0Rt = 8'h01; req0Op = 3'd1;
    req1Rs = 32'h1; req1Rt = 8'h02; req1Op = 3'd1;
    req0Valid = 1'b1; req1Valid = 1'b1; resp0Ready = 1'b1; resp1Ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      vecs++; if (req0Ready !== (k % 2 == 0) || req1Ready !== (k % 2 == 1))
        begin errs++; $display("FAIL contend_grant%0d got %b%b want %b%b", k, req0Ready, req1Ready, k % 2 == 0, k % 2 == 1); end
      repeat (2) @(negedge clock);
      vecs++; if (resp0Valid !== (k % 2 == 0) || resp1Valid !== (k % 2 == 1) || respData !== (k % 2 == 0 ? 32'h2 : 32'h4))
        begin errs++; $display("FAIL contend_resp%0d got v=%b%b d=%h", k, resp0Valid, resp1Valid, respData); end
      @(negedge clock);
    end
    req0Valid = 1'b0; req1Valid = 1'b0; resp0Ready = 1'b0; resp1Ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit stable = 1'b1;
    bit seen = 1'b0;
    @(negedge clock);
    req0Rs = 32'h3; req0Rt = 8'h01; req0Op = 3'd1; req0Valid = 1'b1;
    @(negedge clock);
    req0Valid = 1'b0;
    req1Rs = 32'h5; req1Rt = 8'h00; req1Op = 3'd0; req1Valid = 1'b1;
    resp1Ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      if (resp0Valid !== 1'b1 || respData !== 32'h6 || req1Ready !== 1'b0 || resp1Valid !== 1'b0) stable = 1'b0;
    end
    vecs++; if (!stable) begin errs++; $display("FAIL bp_hold got v0=%b d=%h r1=%b want 1/00000006/0", resp0Valid, respData, req1Ready); end
    resp0Ready = 1'b1;
    @(negedge clock);
    resp0Ready = 1'b0;
    #1;
    vecs++; if (resp0Valid !== 1'b0 || req1Ready !== 1'b1) begin errs++; $display("FAIL bp_release got v0=%b r1=%b want 0/1", resp0Valid, req1Ready); end
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clock);
      if (req1Valid && i == 0) req1Valid = 1'b0;
      if (resp1Valid === 1'b1) seen = 1'b1;
    end
    vecs++; if (!seen || respData !== 32'h5) begin errs++; $display("FAIL bp_req1 got seen=%0b d=%h want 1/00000005", seen, respData); end
    @(negedge clock);
    resp1Ready = 1'b0;
    req1Valid = 1'b0;
  endtask

  task automatic test_illegal();
    @(negedge clock);
    req0Rs = 32'hDEADBEEF; req0Rt = 8'h03; req0Op = 3'd6; req0Valid = 1'b1;
    @(negedge clock);
    req0Valid = 1'b0;
    #1;
    vecs++; if (shOp !== 3'd0) begin errs++; $display("FAIL illegal_shop got %h want 0", shOp); end
    @(negedge clock);
    vecs++; if (resp0Valid !== 1'b1 || respData !== 32'h0 || respErr !== 1'b1)
      begin errs++; $display("FAIL illegal_resp got v=%b d=%h e=%b want 1/00000000/1", resp0Valid, respData, respErr); end
    resp0Ready = 1'b1;
    @(negedge clock);
    resp0Ready = 1'b0;
  endtask

  task automatic test_abort();
    @(negedge clock);
    req0Rs = 32'h1; req0Rt = 8'h01; req0Op = 3'd1; req0Valid = 1'b1;
    @(negedge clock);
    req0Valid = 1'b0;
    reset = 1'b1;
    #1;
    vecs++; if (resp0Valid !== 1'b0 || resp1Valid !== 1'b0 || shOp !== 3'd0)
      begin errs++; $display("FAIL abort_exec got v=%b%b shOp=%h want 00/0", resp0Valid, resp1Valid, shOp); end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    vecs++; if (resp0Valid !== 1'b0) begin errs++; $display("FAIL abort_exec_late got %b want 0", resp0Valid); end
    req0Valid = 1'b1;
    repeat (2) @(negedge clock);
    req0Valid = 1'b0;
    vecs++; if (resp0Valid !== 1'b1) begin errs++; $display("FAIL abort_pre got %b want 1", resp0Valid); end
    reset = 1'b1;
    #1;
    vecs++; if (resp0Valid !== 1'b0 || respData !== 32'h0) begin errs++; $display("FAIL abort_resp got v=%b d=%h want 0/0", resp0Valid, respData); end
    @(negedge clock);
    reset = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b1;
    #1;
    vecs++; if (req0Ready !== 1'b1 || req1Ready !== 1'b0) begin errs++; $display("FAIL abort_tie got %b%b want 10", req0Ready, req1Ready); end
    req0Valid = 1'b0; req1Valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_contention();
    test_backpressure();
    test_illegal();
    test_abort();
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
